hazard_stall_ctrl: RTL and testbench
====================================

HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

Interface
REQ-001 Parameter REG_AW, default 5, register-index width.
REQ-002 Parameter LOAD_LAT, default 1, load-use bubbles required (1..7).
REQ-003 clk  input  1  single clock, rising edge; one clock, reset is asynchronous and active-low.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 id_rs1, id_rs2  input  REG_AW  source indices of instruction in ID.
REQ-006 id_use_rs1, id_use_rs2  input  1  ID instruction actually reads rs1/rs2.
REQ-007 ex_rd  input  REG_AW  destination index of instruction in EX.
REQ-008 ex_mem_read  input  1  EX instruction is a load.
REQ-009 ex_branch_taken  input  1  EX resolved a taken branch/jump.
REQ-010 dmem_req, dmem_ready  input  1  data-memory request in MEM; data/ack valid.
REQ-011 stall_pc, stall_ifid  output  1  hold PC and IF/ID register.
REQ-012 bubble_idex  output  1  load NOP into ID/EX.
REQ-013 flush_ifid  output  1  squash IF/ID contents.
REQ-014 freeze  output  1  hold all pipeline registers, including EX/MEM and MEM/WB.
REQ-015 lu_busy  output  1  state is LU_STALL.

Function
REQ-016 Load-use hazard (lu_hit) SHALL be ex_mem_read && ex_rd!=0 && ((id_use_rs1 && id_rs1==ex_rd) || (id_use_rs2 && id_rs2==ex_rd)); x0 never hazards.
REQ-017 Mem-wait (mw_hit) SHALL be dmem_req && !dmem_ready.
REQ-018 FSM states SHALL be RUN, LU_STALL, MEM_WAIT; reset state RUN.
REQ-019 RUN: mw_hit -> freeze=1, stall_pc=stall_ifid=1, other outputs 0, next MEM_WAIT.
REQ-020 RUN: else ex_branch_taken -> flush_ifid=1, bubble_idex=1, no stall, stay RUN (branch overrides load-use).
REQ-021 RUN: else lu_hit -> stall_pc=stall_ifid=bubble_idex=1 same cycle; next LU_STALL with counter=LOAD_LAT-1 if LOAD_LAT>1, else stay RUN.
REQ-022 LU_STALL: stall_pc=stall_ifid=bubble_idex=1; counter decrements each cycle; at counter==1 next RUN; lu_busy=1.
REQ-023 LU_STALL: mw_hit SHALL freeze and hold counter unchanged; state stays LU_STALL.
REQ-024 MEM_WAIT: freeze=stall_pc=stall_ifid=1 while mw_hit; first cycle with dmem_ready=1 outputs all 0 except those per RUN rules, next RUN.
REQ-025 During freeze flush_ifid and bubble_idex SHALL be 0; frozen EX re-presents ex_branch_taken after release.
REQ-026 All outputs SHALL be combinational from state, counter and current inputs; no extra latency on detection.
REQ-027 Counter width SHALL be 3 bits; never wraps below 0.

Reset
REQ-028 rst_n low SHALL force state RUN, counter 0, all outputs 0 immediately, independent of clk.
REQ-029 Reset asserted mid-LU_STALL or mid-MEM_WAIT SHALL abandon the stall; first cycle after release behaves as RUN.

Configuration
REQ-030 Macro HAZARD_STATS_EN SHALL add outputs stat_lu_cnt and stat_mw_cnt (32 bits), counting cycles with bubble_idex from lu_hit/LU_STALL and cycles with freeze; saturating at all-ones, cleared by rst_n.
REQ-031 Without HAZARD_STATS_EN those ports and counters SHALL not exist; other behaviour identical.

Structure
REQ-032 Package hazard_pkg SHALL hold the state enum, REG_AW default and LU counter width.
REQ-033 Sub-module hazard_detect SHALL hold the combinational lu_hit compare; FSM and counter live in hazard_stall_ctrl.

Verification
REQ-034 ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1, LOAD_LAT=1 -> one cycle stall_pc=stall_ifid=bubble_idex=1, then 0.
REQ-035 Same with ex_rd=0 or id_use_rs1=0 -> no stall.
REQ-036 LOAD_LAT=3, hit on rs2 -> three consecutive bubble cycles, lu_busy=1 on cycles 2-3.
REQ-037 lu_hit and ex_branch_taken same cycle -> flush_ifid=1, bubble_idex=1, stall_pc=0.
REQ-038 dmem_req=1, dmem_ready=0 for 4 cycles during LU_STALL counter=2 -> freeze 4 cycles, then 2 more bubble cycles.
REQ-039 rst_n pulled low in MEM_WAIT -> outputs 0 asynchronously; with HAZARD_STATS_EN stat counters read 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard / stall controller.
package hazard_pkg;

    localparam int REG_AW_DEF = 5;
    localparam int LU_CW      = 3;

    typedef enum logic [1:0] {
        RUN,
        LU_STALL,
        MEM_WAIT
    } state_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use compare between the ID sources and the EX load destination.
module hazard_detect
    import hazard_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_mem_read,
    output logic              lu_hit
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = id_use_rs1 && (id_rs1 == ex_rd);
    assign rs2_hit = id_use_rs2 && (id_rs2 == ex_rd);

    // x0 is hardwired zero, so a load to it never creates a dependency
    assign lu_hit = ex_mem_read && (ex_rd != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall / flush / freeze controller for load-use and memory waits.
// Optional HAZARD_STATS_EN adds saturating bubble and freeze cycle counters.
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW   = REG_AW_DEF,
    parameter int LOAD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_mem_read,
    input  logic              ex_branch_taken,
    input  logic              dmem_req,
    input  logic              dmem_ready,
    output logic              stall_pc,
    output logic              stall_ifid,
    output logic              bubble_idex,
    output logic              flush_ifid,
    output logic              freeze,
    output logic              lu_busy
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]       stat_lu_cnt,
    output logic [31:0]       stat_mw_cnt
`endif
);

    localparam logic [LU_CW-1:0] LU_INIT = LU_CW'(LOAD_LAT - 1);
    localparam logic [LU_CW-1:0] LU_ONE  = LU_CW'(1);

    state_t           state;
    state_t           state_nx;
    logic [LU_CW-1:0] cnt;
    logic [LU_CW-1:0] cnt_nx;
    logic             lu_hit;
    logic             mw_hit;
    logic             stall;
    logic             bubble;
    logic             flush;
    logic             frz;
    logic             busy;

    hazard_detect #(
        .REG_AW (REG_AW)
    ) u_detect (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .lu_hit      (lu_hit)
    );

    assign mw_hit = dmem_req && !dmem_ready;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        stall    = 1'b0;
        bubble   = 1'b0;
        flush    = 1'b0;
        frz      = 1'b0;
        busy     = 1'b0;
        if (state == LU_STALL) begin
            stall = 1'b1;
            busy  = 1'b1;
            if (mw_hit) begin
                frz = 1'b1;
            end else begin
                bubble = 1'b1;
                if (cnt <= LU_ONE) begin
                    state_nx = RUN;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt - LU_ONE;
                end
            end
        end else if (mw_hit) begin
            frz      = 1'b1;
            stall    = 1'b1;
            state_nx = MEM_WAIT;
        end else begin
            // RUN, or the release cycle of MEM_WAIT
            state_nx = RUN;
            if (ex_branch_taken) begin
                flush  = 1'b1;
                bubble = 1'b1;
            end else if (lu_hit) begin
                stall  = 1'b1;
                bubble = 1'b1;
                if (LOAD_LAT > 1) begin
                    state_nx = LU_STALL;
                    cnt_nx   = LU_INIT;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Outputs are forced low while reset is held, without waiting for a clock
    assign stall_pc    = rst_n & stall;
    assign stall_ifid  = rst_n & stall;
    assign bubble_idex = rst_n & bubble;
    assign flush_ifid  = rst_n & flush;
    assign freeze      = rst_n & frz;
    assign lu_busy     = rst_n & busy;

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_lu_cnt <= '0;
            stat_mw_cnt <= '0;
        end else begin
            if (bubble && !flush && (stat_lu_cnt != '1))
                stat_lu_cnt <= stat_lu_cnt + 32'd1;
            if (frz && (stat_mw_cnt != '1))
                stat_mw_cnt <= stat_mw_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl with LOAD_LAT=1 and LOAD_LAT=3 instances.
module tb_hazard_stall_ctrl;

    logic       clk;
    logic       rst_n;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_use_rs1;
    logic       id_use_rs2;
    logic [4:0] ex_rd;
    logic       ex_mem_read;
    logic       ex_branch_taken;
    logic       dmem_req;
    logic       dmem_ready;

    logic a_spc, a_sif, a_bub, a_fl, a_frz, a_busy;
    logic b_spc, b_sif, b_bub, b_fl, b_frz, b_busy;
    logic [5:0] o1;
    logic [5:0] o3;
`ifdef HAZARD_STATS_EN
    logic [31:0] a_slu, a_smw, b_slu, b_smw;
`endif

    int n_chk;
    int n_fail;

    hazard_stall_ctrl #(.REG_AW(5), .LOAD_LAT(1)) u1 (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_use_rs1      (id_use_rs1),
        .id_use_rs2      (id_use_rs2),
        .ex_rd           (ex_rd),
        .ex_mem_read     (ex_mem_read),
        .ex_branch_taken (ex_branch_taken),
        .dmem_req        (dmem_req),
        .dmem_ready      (dmem_ready),
        .stall_pc        (a_spc),
        .stall_ifid      (a_sif),
        .bubble_idex     (a_bub),
        .flush_ifid      (a_fl),
        .freeze          (a_frz),
        .lu_busy         (a_busy)
`ifdef HAZARD_STATS_EN
        ,
        .stat_lu_cnt     (a_slu),
        .stat_mw_cnt     (a_smw)
`endif
    );

    hazard_stall_ctrl #(.REG_AW(5), .LOAD_LAT(3)) u3 (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_use_rs1      (id_use_rs1),
        .id_use_rs2      (id_use_rs2),
        .ex_rd           (ex_rd),
        .ex_mem_read     (ex_mem_read),
        .ex_branch_taken (ex_branch_taken),
        .dmem_req        (dmem_req),
        .dmem_ready      (dmem_ready),
        .stall_pc        (b_spc),
        .stall_ifid      (b_sif),
        .bubble_idex     (b_bub),
        .flush_ifid      (b_fl),
        .freeze          (b_frz),
        .lu_busy         (b_busy)
`ifdef HAZARD_STATS_EN
        ,
        .stat_lu_cnt     (b_slu),
        .stat_mw_cnt     (b_smw)
`endif
    );

    // packed view: {stall_pc, stall_ifid, bubble_idex, flush_ifid, freeze, lu_busy}
    assign o1 = {a_spc, a_sif, a_bub, a_fl, a_frz, a_busy};
    assign o3 = {b_spc, b_sif, b_bub, b_fl, b_frz, b_busy};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic idle();
        id_rs1          = 5'd0;
        id_rs2          = 5'd0;
        id_use_rs1      = 1'b0;
        id_use_rs2      = 1'b0;
        ex_rd           = 5'd0;
        ex_mem_read     = 1'b0;
        ex_branch_taken = 1'b0;
        dmem_req        = 1'b0;
        dmem_ready      = 1'b0;
    endtask

    task automatic hit_rs1();
        idle();
        ex_mem_read = 1'b1;
        ex_rd       = 5'd5;
        id_rs1      = 5'd5;
        id_use_rs1  = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        hit_rs1();
        dmem_req = 1'b1;
        #1;
        n_chk++;
        if (o1 !== 6'b000000) begin
            n_fail++;
            $display("FAIL reset_lat1: got %b want %b", o1, 6'b000000);
        end
        n_chk++;
        if (o3 !== 6'b000000) begin
            n_fail++;
            $display("FAIL reset_lat3: got %b want %b", o3, 6'b000000);
        end
`ifdef HAZARD_STATS_EN
        n_chk++;
        if (a_slu !== 32'd0 || a_smw !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_stats: got %0d/%0d want 0/0", a_slu, a_smw);
        end
`endif
        @(negedge clk);
        idle();
        rst_n = 1'b1;
        #1;
        n_chk++;
        if (o1 !== 6'b000000) begin
            n_fail++;
            $display("FAIL reset_release: got %b want %b", o1, 6'b000000);
        end
    endtask

    task automatic test_load_use_lat1();
        @(negedge clk);
        hit_rs1();
        #1;
        n_chk++;
        if (o1 !== 6'b111000) begin
            n_fail++;
            $display("FAIL lu1_hit: got %b want %b", o1, 6'b111000);
        end
        @(negedge clk);
        idle();
        #1;
        n_chk++;
        if (o1 !== 6'b000000) begin
            n_fail++;
            $display("FAIL lu1_after: got %b want %b", o1, 6'b000000);
        end
        n_chk++;
        if (o3 !== 6'b111001) begin
            n_fail++;
            $display("FAIL lu3_rs1_c2: got %b want %b", o3, 6'b111001);
        end
        repeat (2) @(negedge clk);
        #1;
        n_chk++;
        if (o3 !== 6'b000000) begin
            n_fail++;
            $display("FAIL lu3_rs1_done: got %b want %b", o3, 6'b000000);
        end
    endtask

    task automatic test_no_hazard();
        for (int v = 0; v < 3; v++) begin
            @(negedge clk);
            hit_rs1();
            case (v)
                0: begin ex_rd = 5'd0; id_rs1 = 5'd0; end
                1: begin id_use_rs1 = 1'b0; id_rs2 = 5'd5; end
                default: ex_mem_read = 1'b0;
            endcase
            #1;
            n_chk++;
            if (o1 !== 6'b000000 || o3 !== 6'b000000) begin
                n_fail++;
                $display("FAIL no_hazard_%0d: got %b/%b want 000000", v, o1, o3);
            end
        end
    endtask

    task automatic test_lat3_rs2();
        logic [5:0] exp3 [4];
        exp3[0] = 6'b111000;
        exp3[1] = 6'b111001;
        exp3[2] = 6'b111001;
        exp3[3] = 6'b000000;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            idle();
            if (c == 0) begin
                ex_mem_read = 1'b1;
                ex_rd       = 5'd7;
                id_rs1      = 5'd3;
                id_use_rs1  = 1'b1;
                id_rs2      = 5'd7;
                id_use_rs2  = 1'b1;
            end
            #1;
            n_chk++;
            if (o3 !== exp3[c]) begin
                n_fail++;
                $display("FAIL lat3_rs2_c%0d: got %b want %b", c, o3, exp3[c]);
            end
        end
    endtask

    task automatic test_branch_override();
        @(negedge clk);
        hit_rs1();
        ex_branch_taken = 1'b1;
        #1;
        n_chk++;
        if (o1 !== 6'b001100 || o3 !== 6'b001100) begin
            n_fail++;
            $display("FAIL branch_over: got %b/%b want 001100", o1, o3);
        end
        @(negedge clk);
        idle();
        #1;
        n_chk++;
        if (o3 !== 6'b000000) begin
            n_fail++;
            $display("FAIL branch_next: got %b want %b", o3, 6'b000000);
        end
    endtask

    task automatic test_mw_in_lu();
        @(negedge clk);
        hit_rs1();
        #1;
        n_chk++;
        if (o3 !== 6'b111000) begin
            n_fail++;
            $display("FAIL mwlu_enter: got %b want %b", o3, 6'b111000);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            idle();
            dmem_req = 1'b1;
            #1;
            n_chk++;
            if (o3 !== 6'b110011 || o1 !== 6'b110010) begin
                n_fail++;
                $display("FAIL mwlu_freeze_c%0d: got %b/%b want 110010/110011",
                         c, o1, o3);
            end
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            idle();
            if (c == 0) begin
                dmem_req   = 1'b1;
                dmem_ready = 1'b1;
            end
            #1;
            n_chk++;
            if (o1 !== 6'b000000) begin
                n_fail++;
                $display("FAIL mwlu_lat1_c%0d: got %b want 000000", c, o1);
            end
            n_chk++;
            if (o3 !== ((c < 2) ? 6'b111001 : 6'b000000)) begin
                n_fail++;
                $display("FAIL mwlu_resume_c%0d: got %b want %b", c, o3,
                         (c < 2) ? 6'b111001 : 6'b000000);
            end
        end
    endtask

    task automatic test_mw_branch();
        @(negedge clk);
        idle();
        dmem_req        = 1'b1;
        ex_branch_taken = 1'b1;
        #1;
        n_chk++;
        if (o1 !== 6'b110010) begin
            n_fail++;
            $display("FAIL mwbr_freeze: got %b want %b", o1, 6'b110010);
        end
        @(negedge clk);
        dmem_ready = 1'b1;
        #1;
        n_chk++;
        if (o1 !== 6'b001100 || o3 !== 6'b001100) begin
            n_fail++;
            $display("FAIL mwbr_release: got %b/%b want 001100", o1, o3);
        end
        @(negedge clk);
        idle();
        #1;
        n_chk++;
        if (o1 !== 6'b000000) begin
            n_fail++;
            $display("FAIL mwbr_after: got %b want %b", o1, 6'b000000);
        end
    endtask

    task automatic test_reset_mid_stall();
        @(negedge clk);
        idle();
        dmem_req = 1'b1;
        #1;
        n_chk++;
        if (o1 !== 6'b110010) begin
            n_fail++;
            $display("FAIL rstmw_pre: got %b want %b", o1, 6'b110010);
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (o1 !== 6'b000000 || o3 !== 6'b000000) begin
            n_fail++;
            $display("FAIL rstmw_async: got %b/%b want 000000", o1, o3);
        end
`ifdef HAZARD_STATS_EN
        n_chk++;
        if (a_slu !== 32'd0 || a_smw !== 32'd0 || b_slu !== 32'd0 || b_smw !== 32'd0) begin
            n_fail++;
            $display("FAIL rstmw_stats: got %0d/%0d/%0d/%0d want 0",
                     a_slu, a_smw, b_slu, b_smw);
        end
`endif
        @(negedge clk);
        idle();
        rst_n = 1'b1;
        #1;
        n_chk++;
        if (o1 !== 6'b000000) begin
            n_fail++;
            $display("FAIL rstmw_run: got %b want %b", o1, 6'b000000);
        end
        @(negedge clk);
        hit_rs1();
        @(negedge clk);
        idle();
        #1;
        n_chk++;
        if (o3 !== 6'b111001) begin
            n_fail++;
            $display("FAIL rstlu_pre: got %b want %b", o3, 6'b111001);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (o3 !== 6'b000000) begin
            n_fail++;
            $display("FAIL rstlu_async: got %b want %b", o3, 6'b000000);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_chk++;
        if (o3 !== 6'b000000) begin
            n_fail++;
            $display("FAIL rstlu_run: got %b want %b", o3, 6'b000000);
        end
        @(negedge clk);
        hit_rs1();
        #1;
        n_chk++;
        if (o3 !== 6'b111000) begin
            n_fail++;
            $display("FAIL rstlu_rehit: got %b want %b", o3, 6'b111000);
        end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        idle();
        test_reset();
        test_load_use_lat1();
        test_no_hazard();
        test_lat3_rs2();
        test_branch_override();
        test_mw_in_lu();
        test_mw_branch();
        test_reset_mid_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
